// File: rtl/dac_write_sched.sv
// Dual-channel parallel DAC write scheduler: round-robin arbitration of two sample
// channels onto a shared 8-bit DAC bus, with optional synchronous LDAC and sticky clear.
module dac_write_sched #(
  parameter int unsigned WR_CYC = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       a_req,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [7:0] b_data,
  output logic       b_ack,
  input  logic       sync_mode,
  input  logic       clr_req,
  output logic       busy,
  output logic [7:0] DB,
  output logic       CS,
  output logic       WR,
  output logic       AB,
  output logic       LDAC,
  output logic       CLR
);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, LOAD, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      db_q, db_d;
  logic            ab_q, ab_d;
  logic            last_b_q, last_b_d;
  logic [1:0]      done_q, done_d;
  logic            pend_q, pend_d;

  logic [1:0]      req;
  logic [1:0][7:0] data;
  logic            gnt;
  logic [1:0]      done_set;

  assign req  = {b_req, a_req};
  assign data = {b_data, a_data};
  // On contention the channel that was not granted last wins; a lone requester always wins.
  assign gnt  = (req == 2'b11) ? ~last_b_q : req[1];

  always_comb begin
    done_set = 2'b00;
    done_set[ab_q] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      db_q     <= '0;
      ab_q     <= 1'b0;
      last_b_q <= 1'b1;
      done_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      ab_q     <= ab_d;
      last_b_q <= last_b_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    db_d     = db_q;
    ab_d     = ab_q;
    last_b_d = last_b_q;
    done_d   = done_q;
    pend_d   = pend_q | clr_req;
    case (state_q)
      IDLE: begin
        // Clear beats any write; a clear request seen here is consumed immediately.
        if (pend_q || clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (|req) begin
          state_d  = SETUP;
          db_d     = data[gnt];
          ab_d     = gnt;
          last_b_d = gnt;
        end
      end
      SETUP: begin
        state_d = WRITE;
        cnt_d   = '0;
      end
      WRITE: begin
        if (cnt_q == 3'(WR_CYC - 1)) state_d = HOLD;
        else                         cnt_d   = cnt_q + 3'd1;
      end
      HOLD: begin
        done_d = done_q | done_set;
        if (!sync_mode || ((done_q | done_set) == 2'b11)) state_d = LOAD;
        else                                              state_d = IDLE;
      end
      LOAD: begin
        done_d  = '0;
        state_d = IDLE;
      end
      CLEAR: begin
        if (cnt_q == 3'd1) begin
          done_d  = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CS    = !(state_q == SETUP || state_q == WRITE || state_q == HOLD);
  assign WR    = (state_q != WRITE);
  assign LDAC  = (state_q != LOAD);
  assign CLR   = (state_q != CLEAR);
  assign a_ack = (state_q == HOLD) && !ab_q;
  assign b_ack = (state_q == HOLD) &&  ab_q;
  assign busy  = (state_q != IDLE);
  assign DB    = db_q;
  assign AB    = ab_q;

endmodule

// File: tb/tb_dac_write_sched.sv
// Bench for dac_write_sched: three builds (WR_CYC=2,1,7) share stimulus and are compared
// every cycle against a per-operation timeline model; directed table and corner sequences.
module tb_dac_write_sched;

  function automatic int wof(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 7;
  endfunction

  logic            Clk = 1'b0;
  logic            Rst;
  logic            a_req, b_req, sync_mode, clr_req;
  logic [7:0]      a_data, b_data;
  logic [2:0][7:0] db;
  logic [2:0]      cs, wr, ab, ldac, clr, aack, back, busy;

  int vecs = 0;
  int errs = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dac_write_sched #(.WR_CYC(wof(g))) u_dut (
      .Clk(Clk), .Rst(Rst),
      .a_req(a_req), .a_data(a_data), .a_ack(aack[g]),
      .b_req(b_req), .b_data(b_data), .b_ack(back[g]),
      .sync_mode(sync_mode), .clr_req(clr_req), .busy(busy[g]),
      .DB(db[g]), .CS(cs[g]), .WR(wr[g]), .AB(ab[g]), .LDAC(ldac[g]), .CLR(clr[g])
    );
  end

  // Model: an operation is either a write (t=0 setup, 1..W strobe, W+1 hold, W+2 load)
  // or a clear (t=0,1); outputs follow from where we are in that timeline.
  typedef struct {
    bit       act;
    bit       clr_op;
    int       t;
    bit       ch;
    bit [7:0] db;
    bit       ab;
    bit [1:0] done;
    bit       pend;
    bit       lastb;
  } mdl_t;

  mdl_t m [3];

  function automatic void mreset(int k);
    m[k] = '{act:0, clr_op:0, t:0, ch:0, db:8'h00, ab:0, done:2'b00, pend:0, lastb:1};
  endfunction

  function automatic void step(int k);
    int w = wof(k);
    bit p = m[k].pend | clr_req;
    bit c;
    if (!m[k].act) begin
      if (p) begin
        m[k].act = 1; m[k].clr_op = 1; m[k].t = 0; p = 0;
      end else if (a_req || b_req) begin
        c = (a_req && b_req) ? !m[k].lastb : b_req;
        m[k].act = 1; m[k].clr_op = 0; m[k].t = 0;
        m[k].ch = c; m[k].ab = c; m[k].lastb = c;
        m[k].db = c ? b_data : a_data;
      end
    end else if (m[k].clr_op) begin
      if (m[k].t == 1) begin m[k].act = 0; m[k].done = 0; end
      else m[k].t++;
    end else if (m[k].t == w + 1) begin
      m[k].done[m[k].ch] = 1;
      if (!sync_mode || m[k].done == 2'b11) m[k].t++;
      else m[k].act = 0;
    end else if (m[k].t == w + 2) begin
      m[k].act = 0; m[k].done = 0;
    end else begin
      m[k].t++;
    end
    m[k].pend = p;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [14:0] e, a;
      bit s, st, h, l, cl;
      int w = wof(k);
      cl = m[k].act && m[k].clr_op;
      s  = m[k].act && !m[k].clr_op && m[k].t == 0;
      st = m[k].act && !m[k].clr_op && m[k].t >= 1 && m[k].t <= w;
      h  = m[k].act && !m[k].clr_op && m[k].t == w + 1;
      l  = m[k].act && !m[k].clr_op && m[k].t == w + 2;
      e = {m[k].db, m[k].ab, !(s || st || h), !st, !l, !cl, h && !m[k].ch, h && m[k].ch, m[k].act};
      a = {db[k], ab[k], cs[k], wr[k], ldac[k], clr[k], aack[k], back[k], busy[k]};
      vecs++;
      if (a !== e) begin
        errs++;
        $display("FAIL model dut%0d (W=%0d) t=%0t: got %h want %h [db,ab,cs,wr,ldac,clr,aack,back,busy]",
                 k, w, $time, a, e);
      end
    end
  endtask

  task automatic cyc(input bit ar, input logic [7:0] ad, input bit br, input logic [7:0] bd,
                     input bit sm, input bit cr);
    @(negedge Clk);
    a_req = ar; a_data = ad; b_req = br; b_data = bd; sync_mode = sm; clr_req = cr;
    #1;
    check_all();
    for (int k = 0; k < 3; k++) step(k);
  endtask

  task automatic rst_pulse();
    a_req = 0; b_req = 0; clr_req = 0; sync_mode = 0; a_data = 0; b_data = 0;
    Rst = 1'b0;
    for (int k = 0; k < 3; k++) mreset(k);
    #1;
    check_all();
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic cmp(input string nm, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  typedef struct {
    bit       ar;
    bit [7:0] ad;
    bit [7:0] e_db;
    bit       e_ab, e_cs, e_wr, e_ld, e_ack, e_busy;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   q [$];
    int   n0, n1, ack_at, clr_at;
    bit   sm;

    tbl[0] = '{1, 8'h5A, 8'h00, 0, 1, 1, 1, 0, 0};
    tbl[1] = '{0, 8'h00, 8'h5A, 0, 0, 1, 1, 0, 1};
    tbl[2] = '{0, 8'h00, 8'h5A, 0, 0, 0, 1, 0, 1};
    tbl[3] = '{0, 8'h00, 8'h5A, 0, 0, 0, 1, 0, 1};
    tbl[4] = '{0, 8'h00, 8'h5A, 0, 0, 1, 1, 1, 1};
    tbl[5] = '{0, 8'h00, 8'h5A, 0, 1, 1, 0, 0, 1};
    tbl[6] = '{0, 8'h00, 8'h5A, 0, 1, 1, 1, 0, 0};

    rst_pulse();

    // Single channel-A write, WR_CYC=2, immediate load.
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].ar, tbl[i].ad, 0, 8'h00, 0, 0);
      vecs++;
      if ({db[0], ab[0], cs[0], wr[0], ldac[0], aack[0], busy[0]} !==
          {tbl[i].e_db, tbl[i].e_ab, tbl[i].e_cs, tbl[i].e_wr, tbl[i].e_ld, tbl[i].e_ack, tbl[i].e_busy}) begin
        errs++;
        $display("FAIL table row %0d: got %h/%b%b%b%b%b%b want %h/%b%b%b%b%b%b", i,
                 db[0], ab[0], cs[0], wr[0], ldac[0], aack[0], busy[0],
                 tbl[i].e_db, tbl[i].e_ab, tbl[i].e_cs, tbl[i].e_wr, tbl[i].e_ld, tbl[i].e_ack, tbl[i].e_busy);
      end
    end

    // Both channels requesting from reset: grants must alternate starting with A.
    rst_pulse();
    for (int i = 0; i < 26; i++) begin
      cyc(1, 8'hA1, 1, 8'hB2, 0, 0);
      if (aack[0]) q.push_back(0);
      if (back[0]) q.push_back(1);
    end
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cmp($sformatf("rr order %0d", i), (i < q.size()) ? q[i] : 9, i % 2);

    // Synchronous load: nothing after A, exactly one LDAC after B.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(i == 0, 8'h10, 0, 8'h00, 1, 0);
      if (!ldac[0]) n0++;
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 8'h00, i == 0, 8'hF0, 1, 0);
      if (!ldac[0]) n1++;
    end
    cmp("sync ldac after A", n0, 0);
    cmp("sync ldac after B", n1, 1);

    // Clear requested while B is strobing: B completes, then a 2-cycle clear.
    n0 = 0; n1 = 0; ack_at = -1; clr_at = -1;
    for (int i = 0; i < 17; i++) begin
      cyc(0, 8'h00, i == 0, 8'h77, 0, i == 2);
      if (back[0]) begin n0++; ack_at = i; end
      if (!clr[0]) begin n1++; if (clr_at < 0) clr_at = i; end
    end
    cmp("clr b_ack count", n0, 1);
    cmp("clr low cycles", n1, 2);
    cmp("clr after ack", (clr_at > ack_at) ? 1 : 0, 1);

    // Reset in the middle of a write: immediate abort, no ack or LDAC afterwards.
    cyc(0, 8'h00, 1, 8'h3C, 0, 0);
    cyc(0, 8'h00, 0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 8'h00, 0, 0);
    rst_pulse();
    n0 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 8'h00, 0, 8'h00, 0, 0);
      for (int k = 0; k < 3; k++) if (!ldac[k] || aack[k] || back[k]) n0++;
    end
    cmp("post-reset ack/ldac", n0, 0);

    // Random traffic against the model for all three builds.
    sm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) sm = !sm;
      cyc($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 4, 8'($urandom),
          sm, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dac_write_sched.md
DAC_WRITE_SCHED -- requirements
Module: dac_write_sched

Interface
REQ-001 SHALL have parameter WR_CYC, default 2, WR low-pulse width in Clk cycles (legal 1..7).
REQ-002 SHALL have port Clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port Rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports a_req input 1, a_data input 8, a_ack output 1: channel A sample request, sample, and one-cycle acknowledge.
REQ-005 SHALL have ports b_req input 1, b_data input 8, b_ack output 1: the same for channel B.
REQ-006 SHALL have port sync_mode, input, 1: 1 = LDAC only after both channels are written; 0 = LDAC after every write.
REQ-007 SHALL have port clr_req, input, 1: single-cycle request to clear both DAC outputs.
REQ-008 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-009 SHALL have DAC bus ports DB output 8, CS output 1, WR output 1, AB output 1, LDAC output 1, CLR output 1; CS/WR/LDAC/CLR are active-low; AB 0 = DAC A, 1 = DAC B.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, WRITE, HOLD, LOAD, CLEAR, all registered.
REQ-011 IDLE: a pending clear SHALL take priority -> CLEAR; otherwise, if any req is high, SHALL grant one channel -> SETUP; otherwise stay.
REQ-012 Arbitration SHALL be round-robin: single requester wins; on simultaneous a_req/b_req the channel not granted last wins; last-grant flag resets to B, so A wins first.
REQ-013 SETUP (1 cycle): SHALL latch the granted data into DB, drive AB to the granted channel, CS=0, WR=1.
REQ-014 WRITE: SHALL hold WR=0, CS=0 for exactly WR_CYC cycles (internal counter), DB/AB stable, then -> HOLD.
REQ-015 HOLD (1 cycle): SHALL drive WR=1, CS=0, DB/AB held, and pulse the granted channel's ack high for this cycle only.
REQ-016 On leaving HOLD, CS SHALL return to 1; the written channel's done flag SHALL be set.
REQ-017 After HOLD: sync_mode=0 -> LOAD; sync_mode=1 and both done flags set -> LOAD; otherwise -> IDLE. sync_mode SHALL be sampled in HOLD only.
REQ-018 LOAD (1 cycle): LDAC=0, both done flags cleared, then -> IDLE.
REQ-019 Request-to-ack latency SHALL be exactly WR_CYC+2 cycles after the IDLE grant cycle; back-to-back writes SHALL be separated by at least one IDLE cycle.
REQ-020 clr_req SHALL set a sticky pending flag in any state; an in-progress write/load SHALL complete before CLEAR is entered.
REQ-021 CLEAR: CLR=0 for exactly 2 cycles, CS=WR=LDAC=1, done flags and pending flag cleared, then -> IDLE.
REQ-022 A request whose req drops before grant SHALL NOT be serviced; req held after ack SHALL be treated as a new request.
REQ-023 DB SHALL hold its last written value outside SETUP..HOLD.

Reset
REQ-024 On Rst low, asynchronously: state=IDLE, DB=0x00, CS=WR=LDAC=CLR=1, AB=0, a_ack=b_ack=0, busy=0, done flags/clear pending/counter=0, last-grant=B.
REQ-025 Reset asserted mid-write SHALL abort immediately with no ack issued; no LDAC pulse SHALL follow release.

Verification
REQ-026 WR_CYC=2, sync_mode=0, a_req with a_data=0x5A -> AB=0, DB=0x5A, WR low 2 cycles, a_ack 4 cycles after grant, one-cycle LDAC pulse next.
REQ-027 a_req and b_req asserted together from reset -> A serviced first, then B; grants alternate A,B,A,B while both stay high.
REQ-028 sync_mode=1, write A=0x10 then B=0xF0 -> no LDAC after A; exactly one LDAC pulse after B's HOLD.
REQ-029 clr_req pulsed during WRITE of channel B -> B write completes with b_ack, then CLR low exactly 2 cycles, done flags cleared.
REQ-030 Rst pulsed low during WRITE -> outputs return to reset values same cycle, no ack, no LDAC after release.
REQ-031 WR_CYC=1 and WR_CYC=7 builds -> WR low width 1 and 7 cycles; ack latency 3 and 9 cycles.
